mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_grant.sv | 40 ++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory arbiter.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (alternating grant on contention).
package mem_arb_pkg;

  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_ADD_WIDTH  = 10;
  localparam int LINE_WIDTH     = 4 * MEM_DATA_WIDTH;
  localparam int BURST_LEN      = 4;

  localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    RESP
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant pick between the I and D refill ports.
// MEM_ARB_ROUND_ROBIN_EN adds a last-grant register so contention alternates.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic  clk,
  input  logic  rst,
  input  logic  take,
`endif
  input  logic  i_req,
  input  logic  d_req,
  output port_e gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  port_e last_grant;

  // Remember the winner of each committed grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant <= PORT_I;
    else if (take) last_grant <= gnt;
  end

  // Sole requester wins; on contention the port not served last wins.
  always_comb begin
    gnt = PORT_D;
    if (i_req && d_req)
      gnt = (last_grant == PORT_I) ? PORT_D : PORT_I;
    else if (i_req)
      gnt = PORT_I;
  end
`else
  // D wins any contention.
  always_comb begin
    gnt = (i_req && !d_req) ? PORT_I : PORT_D;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one burst-oriented memory between I and D cache refill ports.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_grant).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADD_WIDTH  = MEM_ADD_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADD_WIDTH-3:0]    i_blk_addr,
  output logic                    i_ack,
  output logic [4*DATA_WIDTH-1:0] i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADD_WIDTH-3:0]    d_blk_addr,
  input  logic [4*DATA_WIDTH-1:0] d_wdata,
  output logic                    d_ack,
  output logic [4*DATA_WIDTH-1:0] d_rdata,
  output logic [ADD_WIDTH-1:0]    mem_add,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic [4*DATA_WIDTH-1:0] mem_read_data,
  input  logic                    mem_ready_to_read,
  input  logic                    mem_finished_writing,
  output logic                    busy,
  output logic                    mem_sync_err
);

  localparam int LW = 4 * DATA_WIDTH;

  state_e               state;
  port_e                gnt;
  port_e                pick;
  logic [1:0]           beat;
  logic [1:0]           next_beat;
  logic [ADD_WIDTH-3:0] blk;
  logic                 we;
  logic [LW-1:0]        wdata;
  logic [DATA_WIDTH-1:0] next_word;
  logic [LW-1:0]        i_rdata_q;
  logic [LW-1:0]        d_rdata_q;
  logic                 take;

  assign take = (state == IDLE) && (i_req || d_req);
  assign busy = (state != IDLE);

  mem_arb_grant u_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk   (clk),
    .rst   (rst),
    .take  (take),
`endif
    .i_req (i_req),
    .d_req (d_req),
    .gnt   (pick)
  );

  // Address and data word for the following write beat.
  always_comb begin
    next_beat = beat + 2'd1;
    next_word = wdata[int'(next_beat)*DATA_WIDTH +: DATA_WIDTH];
  end

  // During the ack cycle the line comes straight from memory, then it is held.
  assign i_rdata = i_ack ? mem_read_data : i_rdata_q;
  assign d_rdata = (d_ack && !we) ? mem_read_data : d_rdata_q;

  // Arbiter FSM: grant, 4-beat strobe burst, then one response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      gnt            <= PORT_I;
      beat           <= 2'd0;
      blk            <= '0;
      we             <= 1'b0;
      wdata          <= '0;
      mem_add        <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      i_ack          <= 1'b0;
      d_ack          <= 1'b0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
      mem_sync_err   <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          beat <= 2'd0;
          if (take) begin
            gnt   <= pick;
            wdata <= d_wdata;
            if (pick == PORT_D) begin
              blk     <= d_blk_addr;
              mem_add <= {d_blk_addr, 2'b00};
            end else begin
              blk     <= i_blk_addr;
              mem_add <= {i_blk_addr, 2'b00};
            end
            if (pick == PORT_D && d_we) begin
              we             <= 1'b1;
              mem_write      <= 1'b1;
              mem_write_data <= d_wdata[DATA_WIDTH-1:0];
              state          <= WR_BURST;
            end else begin
              we       <= 1'b0;
              mem_read <= 1'b1;
              state    <= RD_BURST;
            end
          end
        end
        RD_BURST: begin
          beat <= next_beat;
          if (beat == LAST_BEAT) begin
            mem_read <= 1'b0;
            mem_add  <= '0;
            i_ack    <= (gnt == PORT_I);
            d_ack    <= (gnt == PORT_D);
            state    <= RESP;
          end
        end
        WR_BURST: begin
          beat <= next_beat;
          if (beat == LAST_BEAT) begin
            mem_write      <= 1'b0;
            mem_add        <= '0;
            mem_write_data <= '0;
            d_ack          <= 1'b1;
            state          <= RESP;
          end else begin
            mem_add        <= {blk, next_beat};
            mem_write_data <= next_word;
          end
        end
        RESP: begin
          if (!we) begin
            if (gnt == PORT_I) i_rdata_q <= mem_read_data;
            else d_rdata_q <= mem_read_data;
          end
          if (we ? !mem_finished_writing : !mem_ready_to_read)
            mem_sync_err <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a burst-counting memory model.
// Honours MEM_ARB_ROUND_ROBIN_EN for the expected grant order.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_req = 1'b0;
  logic [7:0]   i_blk_addr = '0;
  logic         i_ack;
  logic [127:0] i_rdata;
  logic         d_req = 1'b0;
  logic         d_we = 1'b0;
  logic [7:0]   d_blk_addr = '0;
  logic [127:0] d_wdata = '0;
  logic         d_ack;
  logic [127:0] d_rdata;
  logic [9:0]   mem_add;
  logic [31:0]  mem_write_data;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] mem_read_data = '0;
  logic         mem_ready_to_read = 1'b0;
  logic         mem_finished_writing = 1'b0;
  logic         busy;
  logic         mem_sync_err;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_blk_addr(i_blk_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_blk_addr(d_blk_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_add(mem_add), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data),
    .mem_ready_to_read(mem_ready_to_read),
    .mem_finished_writing(mem_finished_writing),
    .busy(busy), .mem_sync_err(mem_sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [9:0] a);
    if (a >= 10'h014 && a <= 10'h017) return 32'(a - 10'h013);
    return 32'h5A000000 ^ (32'(a) * 32'h00010193);
  endfunction

  // Memory model: words written on strobe edges, flags pulse after every 4th beat.
  bit [31:0] mem [0:1023];
  bit        mem_wr [0:1023];
  logic [1:0] mcnt = 2'd0;

  function automatic logic [31:0] mrd(input logic [9:0] a);
    return mem_wr[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    mem_ready_to_read <= 1'b0;
    mem_finished_writing <= 1'b0;
    if (mem_read || mem_write) begin
      if (mem_write) begin
        mem[mem_add] <= mem_write_data;
        mem_wr[mem_add] <= 1'b1;
      end
      mcnt <= mcnt + 2'd1;
      if (mcnt == 2'd3) begin
        if (mem_read) begin
          mem_read_data <= {mrd({mem_add[9:2], 2'd3}), mrd({mem_add[9:2], 2'd2}),
                            mrd({mem_add[9:2], 2'd1}), mrd({mem_add[9:2], 2'd0})};
          mem_ready_to_read <= 1'b1;
        end else begin
          mem_finished_writing <= 1'b1;
        end
      end
    end
  end

  // Reference model: plain word array of what memory should hold.
  bit [31:0] ref_mem [0:1023];
  bit        ref_wr  [0:1023];

  function automatic logic [127:0] ref_line(input logic [7:0] b);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) begin
      logic [9:0] a;
      a = {b, 2'(k)};
      l[32*k +: 32] = ref_wr[a] ? ref_mem[a] : init_word(a);
    end
    return l;
  endfunction

  typedef struct {
    logic [127:0] line;
    bit           chkd;
    bit           sync;
  } exp_t;

  exp_t  i_q[$];
  exp_t  d_q[$];
  string ack_log[$];
  int    i_ack_cyc[$];
  int    d_ack_cyc[$];
  bit    exp_sync = 1'b0;

  int    run = 0;
  int    strobe_total = 0;
  int    first_strobe_cyc = 0;
  logic [9:0] first_strobe_add = '0;
  int    acks = 0;
  bit    pend = 1'b0;
  bit    pend_i = 1'b0;
  exp_t  pend_e;

  // Monitor: strobe protocol, idle outputs, and ack scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("sync_err_after_ack", mem_sync_err, pend_e.sync);
        if (pend_e.chkd)
          chk(pend_i ? "i_rdata_held" : "d_rdata_held",
              pend_i ? i_rdata : d_rdata, pend_e.line);
        pend = 1'b0;
      end
      if (mem_read || mem_write) begin
        if (run == 0) begin
          first_strobe_cyc = cyc;
          first_strobe_add = mem_add;
        end
        chk("one_strobe", mem_read & mem_write, 1'b0);
        chk("beat_addr", mem_add[1:0], mem_write ? 2'(run) : 2'd0);
        run++;
        strobe_total++;
      end else begin
        if (run != 0) begin
          chk("burst_len", run, 4);
          run = 0;
        end
        chk("idle_outputs", {mem_add, mem_write_data}, '0);
      end
      if (i_ack && d_ack) begin
        checks++;
        errors++;
        $display("FAIL both_acks: got i=1 d=1 expected one");
      end else if (i_ack || d_ack) begin
        acks++;
        if ((i_ack ? i_q.size() : d_q.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack on %s expected none",
                   i_ack ? "I" : "D");
        end else begin
          pend_i = i_ack;
          pend_e = i_ack ? i_q.pop_front() : d_q.pop_front();
          if (pend_e.chkd)
            chk(i_ack ? "i_rdata" : "d_rdata",
                i_ack ? i_rdata : d_rdata, pend_e.line);
          pend = 1'b1;
        end
        ack_log.push_back(i_ack ? "I" : "D");
        if (i_ack) i_ack_cyc.push_back(cyc);
        else d_ack_cyc.push_back(cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input bit is_d);
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (is_d ? d_ack : i_ack) return;
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout: got no %s ack expected one within 100 cycles",
             is_d ? "D" : "I");
  endtask

  task automatic idle_wait();
    for (int n = 0; n < 50; n++) begin
      if (!busy && !i_req && !d_req) return;
      step(1);
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got busy expected idle");
  endtask

  task automatic i_seq(input int n, input logic [7:0] blk0,
                       input bit rnd, input bit chkd);
    exp_t e;
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = rnd ? 8'($urandom_range(0, 31)) : blk0;
      e.line = ref_line(b);
      e.chkd = chkd;
      e.sync = exp_sync;
      i_q.push_back(e);
      i_blk_addr = b;
      i_req = 1'b1;
      wait_ack(1'b0);
    end
    i_req = 1'b0;
  endtask

  // mode: 0 read, 1 write, 2 random.
  task automatic d_seq(input int n, input int mode, input logic [7:0] blk0,
                       input bit rnd, input logic [127:0] line0);
    exp_t e;
    logic [7:0] b;
    logic [127:0] l;
    bit w;
    for (int k = 0; k < n; k++) begin
      b = rnd ? 8'($urandom_range(32, 63)) : blk0;
      w = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
      l = rnd ? {$urandom, $urandom, $urandom, $urandom} : line0;
      if (w) begin
        for (int j = 0; j < 4; j++) begin
          ref_mem[{b, 2'(j)}] = l[32*j +: 32];
          ref_wr[{b, 2'(j)}] = 1'b1;
        end
        e.line = '0;
        e.chkd = 1'b0;
      end else begin
        e.line = ref_line(b);
        e.chkd = 1'b1;
      end
      e.sync = exp_sync;
      d_q.push_back(e);
      d_blk_addr = b;
      d_we = w;
      d_wdata = l;
      d_req = 1'b1;
      wait_ack(1'b1);
    end
    d_req = 1'b0;
  endtask

  function automatic string log_str();
    string s;
    s = "";
    foreach (ack_log[k]) s = {s, ack_log[k]};
    return s;
  endfunction

  initial begin
    int c0;
    int s0;
    int a0;
    string s;
    string exp_order;

    step(2);
    chk("reset_outputs",
        {i_ack, d_ack, mem_read, mem_write, busy, mem_sync_err, mem_add,
         mem_write_data}, '0);
    chk("reset_rdata", i_rdata | d_rdata, '0);

    // Contention right at reset release: D wins first in both modes.
    fork
      i_seq(1, 8'h0A, 1'b0, 1'b1);
      d_seq(1, 0, 8'h30, 1'b0, '0);
      begin
        step(1);
        rst = 1'b0;
      end
    join
    step(1);
    s = log_str();
    checks++;
    if (s != "DI") begin
      errors++;
      $display("FAIL contention_order: got %s expected DI", s);
    end

    // Single I read, timing and data.
    idle_wait();
    c0 = cyc;
    i_seq(1, 8'h05, 1'b0, 1'b1);
    chk("i_ack_cycle", cyc, c0 + 5);
    chk("i_read_line", i_rdata, 128'h00000004_00000003_00000002_00000001);
    chk("rd_first_strobe", first_strobe_cyc, c0 + 1);
    chk("rd_addr", first_strobe_add, 10'h014);

    // D write then read back.
    idle_wait();
    c0 = cyc;
    d_seq(1, 1, 8'h3F, 1'b0, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA);
    chk("d_wr_ack_cycle", cyc, c0 + 5);
    chk("wr_addr0", first_strobe_add, 10'h0FC);
    chk("mem_0FC", mrd(10'h0FC), 32'h0000AAAA);
    chk("mem_0FD", mrd(10'h0FD), 32'h0000BBBB);
    chk("mem_0FE", mrd(10'h0FE), 32'h0000CCCC);
    chk("mem_0FF", mrd(10'h0FF), 32'h0000DDDD);
    d_seq(1, 0, 8'h3F, 1'b0, '0);
    chk("d_readback", d_rdata, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA);

    // Persistent requesters on both ports.
    step(1);
    idle_wait();
    ack_log.delete();
    fork
      i_seq(2, 8'h07, 1'b0, 1'b1);
      d_seq(3, 0, 8'h21, 1'b0, '0);
    join
    step(1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = "DIDID";
`else
    exp_order = "DDDII";
`endif
    s = log_str();
    checks++;
    if (s != exp_order) begin
      errors++;
      $display("FAIL grant_order: got %s expected %s", s, exp_order);
    end

    // Back-to-back D reads with req held through two acks.
    idle_wait();
    d_ack_cyc.delete();
    s0 = strobe_total;
    d_seq(2, 0, 8'h22, 1'b0, '0);
    @(negedge clk);
    #1;
    chk("b2b_acks", d_ack_cyc.size(), 2);
    if (d_ack_cyc.size() == 2)
      chk("b2b_spacing", d_ack_cyc[1] - d_ack_cyc[0], 6);
    chk("b2b_strobes", strobe_total - s0, 8);
    chk("b2b_sync_err", mem_sync_err, 1'b0);

    // I request raised during beat 1 of a D burst.
    step(1);
    idle_wait();
    i_ack_cyc.delete();
    d_ack_cyc.delete();
    fork
      d_seq(1, 0, 8'h23, 1'b0, '0);
      begin
        step(2);
        i_seq(1, 8'h09, 1'b0, 1'b1);
      end
    join
    @(negedge clk);
    #1;
    if (i_ack_cyc.size() == 1 && d_ack_cyc.size() == 1)
      chk("late_i_spacing", i_ack_cyc[0] - d_ack_cyc[0], 6);
    else
      chk("late_i_acks", {i_ack_cyc.size(), d_ack_cyc.size()}, {32'd1, 32'd1});

    // Random traffic; I and D touch disjoint line ranges.
    step(1);
    fork
      for (int r = 0; r < 25; r++) begin
        i_seq($urandom_range(1, 2), 8'h00, 1'b1, 1'b1);
        step($urandom_range(0, 3));
      end
      for (int r = 0; r < 25; r++) begin
        d_seq($urandom_range(1, 2), 2, 8'h20, 1'b1, '0);
        step($urandom_range(2, 4));
      end
    join
    step(2);

    // Reset in beat 2 aborts the burst; next read flags misalignment.
    idle_wait();
    a0 = acks;
    i_blk_addr = 8'h0C;
    i_req = 1'b1;
    step(1);
    i_req = 1'b0;
    chk("abort_strobing", mem_read, 1'b1);
    step(2);
    rst = 1'b1;
    #1;
    chk("abort_outputs",
        {i_ack, d_ack, mem_read, mem_write, busy, mem_add, mem_write_data},
        '0);
    chk("abort_rdata", i_rdata | d_rdata, '0);
    step(2);
    rst = 1'b0;
    step(1);
    chk("abort_no_ack", acks, a0);
    exp_sync = 1'b1;
    i_seq(1, 8'h02, 1'b0, 1'b0);
    step(2);
    chk("sync_err_sticky", mem_sync_err, 1'b1);

    chk("i_q_empty", i_q.size(), 0);
    chk("d_q_empty", d_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
